// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver with 3-sample majority vote, optional
//            parity, and parity/framing error strobes. Define UART_RX_SYNC_EN
//            to add a 2-flop synchronizer on RX_IN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      Data_Valid,
  output logic                      PAR_ERR,
  output logic                      STP_ERR,
  output logic                      busy
);

  localparam int c_bit_cnt_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_bit_cnt_w-1:0] c_last_bit = c_bit_cnt_w'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t                    r_state, w_next_state;
  logic                      w_rx;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [c_bit_cnt_w-1:0]    r_bit_cnt;
  logic [2:0]                r_samp;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_par_err;
  logic                      r_stop_bit;
  logic [PRESCALE_WIDTH-1:0] w_half;
  logic                      w_last_edge;
  logic                      w_decide;
  logic                      w_majority;
  logic                      w_start;
  logic                      w_frame_good;
  logic                      w_par_fail;
  logic                      w_stp_fail;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Reset to the idle level so a reset release is never seen as a start bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], RX_IN};
  end
  assign w_rx = r_sync[1];
`else
  assign w_rx = RX_IN;
`endif

  assign w_half      = r_prescale >> 1;
  assign w_last_edge = (r_edge_cnt == r_prescale - PRESCALE_WIDTH'(1));
  assign w_decide    = (r_edge_cnt == w_half + PRESCALE_WIDTH'(2));
  assign w_majority  = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) |
                       (r_samp[1] & r_samp[2]);
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_frame_good = 1'b0;
    w_par_fail   = 1'b0;
    w_stp_fail   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_next_state = S_START;
          w_start      = 1'b1;
        end
      end
      S_START: begin
        if (w_decide && w_majority) w_next_state = S_IDLE;
        else if (w_last_edge)       w_next_state = S_DATA;
      end
      S_DATA: begin
        if (w_last_edge && (r_bit_cnt == c_last_bit))
          w_next_state = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_last_edge) w_next_state = S_STOP;
      end
      S_STOP: begin
        if (w_last_edge) begin
          w_par_fail   = r_par_err;
          w_stp_fail   = ~r_stop_bit;
          w_frame_good = r_stop_bit & ~r_par_err;
          // A low stop bit may be the start of a break; wait for the line to recover
          w_next_state = r_stop_bit ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (w_rx) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_samp     <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_stop_bit <= 1'b0;
    end else begin
      if (w_start) begin
        r_prescale <= Prescale;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
      end

      // The detect cycle itself is edge 0 of the start bit
      if (w_start)
        r_edge_cnt <= PRESCALE_WIDTH'(1);
      else if ((w_next_state == S_IDLE) || (w_next_state == S_WAIT_IDLE) || w_last_edge)
        r_edge_cnt <= '0;
      else
        r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);

      if (w_start)
        r_bit_cnt <= '0;
      else if ((r_state == S_DATA) && w_last_edge)
        r_bit_cnt <= (r_bit_cnt == c_last_bit) ? '0 : r_bit_cnt + c_bit_cnt_w'(1);

      if (r_edge_cnt == w_half - PRESCALE_WIDTH'(1)) r_samp[0] <= w_rx;
      if (r_edge_cnt == w_half)                      r_samp[1] <= w_rx;
      if (r_edge_cnt == w_half + PRESCALE_WIDTH'(1)) r_samp[2] <= w_rx;

      if ((r_state == S_DATA) && w_decide)
        r_shift <= {w_majority, r_shift[DATA_WIDTH-1:1]};

      if (w_start)
        r_par_err <= 1'b0;
      else if ((r_state == S_PARITY) && w_decide)
        r_par_err <= w_majority ^ (^r_shift) ^ r_par_typ;

      if ((r_state == S_STOP) && w_decide)
        r_stop_bit <= w_majority;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      Data_Valid <= w_frame_good;
      PAR_ERR    <= w_par_fail;
      STP_ERR    <= w_stp_fail;
      if (w_frame_good) P_DATA <= r_shift;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int n_checks;
  int n_errors;
  int cyc;
  int dv_cnt;
  int dv_cyc;
  int per_cnt;
  int ser_cnt;
  int busy_cnt;

  uart_rx #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_IN     (rx_in),
    .Prescale  (prescale),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .P_DATA    (p_data),
    .Data_Valid(data_valid),
    .PAR_ERR   (par_err),
    .STP_ERR   (stp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cyc      = 0;
    dv_cnt   = 0;
    dv_cyc   = -1;
    per_cnt  = 0;
    ser_cnt  = 0;
    busy_cnt = 0;
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
    end
    if (par_err) per_cnt++;
    if (stp_err) ser_cnt++;
    if (busy)    busy_cnt++;
  endtask

  task automatic hold_line(input int n, input logic val);
    rx_in = val;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives start, 8 data bits LSB first, optional parity, stop; each bit p cycles.
  // The sample at (flip_bit, flip_edge) is inverted to model a noise spike.
  task automatic send_frame(input logic [7:0] data, input logic with_par,
                            input logic par_bit, input logic stop_bit, input int p,
                            input int flip_bit, input int flip_edge);
    logic [10:0] fr;
    int          n;
    fr      = '0;
    fr[8:1] = data;
    if (with_par) begin
      fr[9]  = par_bit;
      fr[10] = stop_bit;
      n      = 11;
    end else begin
      fr[9]  = stop_bit;
      n      = 10;
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < p; j++) begin
        rx_in = ((i == flip_bit) && (j == flip_edge)) ? ~fr[i] : fr[i];
        tick();
      end
    end
    rx_in = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_mon();
    rst      = 1'b1;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;

    // Reset state
    hold_line(3, 1'b1);
    check("rst_p_data", 32'(p_data), 32'h0);
    check("rst_dv", 32'(data_valid), 32'h0);
    check("rst_par_err", 32'(par_err), 32'h0);
    check("rst_stp_err", 32'(stp_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    hold_line(4, 1'b1);

    // Good frame with even parity, P=8: 11 bits * 8 = 88 cycles
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, -1, -1);
    check("a_dv_cnt", 32'(dv_cnt), 32'd1);
    check("a_dv_latency", 32'(dv_cyc), 32'd88);
    check("a_p_data", 32'(p_data), 32'hA5);
    check("a_par_err", 32'(per_cnt), 32'd0);
    check("a_stp_err", 32'(ser_cnt), 32'd0);
    check("a_busy_cycles", 32'(busy_cnt), 32'd87);
    check("a_busy_end", 32'(busy), 32'd0);
    hold_line(4, 1'b1);

    // No parity, P=16, two frames with zero gap
    prescale = 6'd16; par_en = 1'b0;
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16, -1, -1);
    check("b_dv_cnt1", 32'(dv_cnt), 32'd1);
    check("b_dv_latency1", 32'(dv_cyc), 32'd160);
    check("b_p_data1", 32'(p_data), 32'h3C);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16, -1, -1);
    check("b_dv_cnt2", 32'(dv_cnt), 32'd2);
    check("b_dv_latency2", 32'(dv_cyc), 32'd320);
    check("b_p_data2", 32'(p_data), 32'hFF);
    hold_line(4, 1'b1);

    // Odd parity, 0x01 needs parity 0; send 1
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1;
    clear_mon();
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 8, -1, -1);
    hold_line(4, 1'b1);
    check("c_par_err_cnt", 32'(per_cnt), 32'd1);
    check("c_dv_cnt", 32'(dv_cnt), 32'd0);
    check("c_stp_err_cnt", 32'(ser_cnt), 32'd0);
    check("c_p_data_kept", 32'(p_data), 32'hFF);
    check("c_busy", 32'(busy), 32'd0);

    // Framing error followed by a 40-cycle break
    par_typ = 1'b0;
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 8, -1, -1);
    hold_line(40, 1'b0);
    check("d_stp_err_cnt", 32'(ser_cnt), 32'd1);
    check("d_par_err_cnt", 32'(per_cnt), 32'd0);
    check("d_dv_cnt", 32'(dv_cnt), 32'd0);
    check("d_busy_break", 32'(busy), 32'd1);
    hold_line(1, 1'b1);
    check("d_busy_release", 32'(busy), 32'd0);
    hold_line(4, 1'b1);

    // 3-cycle glitch: START for edges 1..6, back to IDLE with no strobe
    par_en = 1'b0;
    clear_mon();
    hold_line(3, 1'b0);
    hold_line(12, 1'b1);
    check("e_busy_cycles", 32'(busy_cnt), 32'd6);
    check("e_strobes", 32'(dv_cnt + per_cnt + ser_cnt), 32'd0);
    check("e_busy", 32'(busy), 32'd0);

    // Noise spike at edge P/2 of data bit 3 (frame bit 4) is outvoted
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8, 4, 4);
    check("f_dv_cnt", 32'(dv_cnt), 32'd1);
    check("f_dv_latency", 32'(dv_cyc), 32'd80);
    check("f_p_data", 32'(p_data), 32'h55);
    hold_line(4, 1'b1);

    // Reset during data bit 4 of 0x81 (bits LSB first: 1,0,0,0,0,...)
    clear_mon();
    hold_line(8, 1'b0);
    hold_line(8, 1'b1);
    hold_line(8, 1'b0);
    hold_line(8, 1'b0);
    hold_line(8, 1'b0);
    hold_line(3, 1'b0);
    rst   = 1'b1;
    rx_in = 1'b1;
    #1;
    check("g_rst_p_data", 32'(p_data), 32'h0);
    check("g_rst_busy", 32'(busy), 32'd0);
    check("g_rst_strobes", 32'({data_valid, par_err, stp_err}), 32'd0);
    hold_line(2, 1'b1);
    rst = 1'b0;
    hold_line(4, 1'b1);
    clear_mon();
    send_frame(8'h42, 1'b0, 1'b0, 1'b1, 8, -1, -1);
    hold_line(4, 1'b1);
    check("g_dv_cnt", 32'(dv_cnt), 32'd1);
    check("g_dv_latency", 32'(dv_cyc), 32'd80);
    check("g_p_data", 32'(p_data), 32'h42);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
